// File: rtl/ir_cfg_sequencer.sv
// Streams camera config frames (AA LEN .. EB AA) from a combinational byte table to a UART TX,
// with optional per-frame ACK wait, timeout and retry.
module ir_cfg_sequencer #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MAX_FRAMES = 16,
   parameter int unsigned GAP_CYCLES = 50000,
   parameter int unsigned ACK_EN     = 1,
   parameter logic [7:0]  ACK_BYTE   = 8'h55,
   parameter int unsigned ACK_TMO    = 100000,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic              iClk,
   input  logic              iRst_N,
   input  logic              iStart,
   output logic [ADDR_W-1:0] oRomAddr,
   input  logic [7:0]        iRomData,
   output logic [7:0]        oTxData,
   output logic              oTxValid,
   input  logic              iTxReady,
   input  logic [7:0]        iRxData,
   input  logic              iRxValid,
   output logic              oBusy,
   output logic              oDone,
   output logic              oErr,
   output logic [4:0]        oFrameCnt
);

   localparam int unsigned TW  = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
   localparam int unsigned SW  = TW + 1;
   localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned TMW = (ACK_TMO > 1) ? $clog2(ACK_TMO + 1) : 1;
   localparam int unsigned RW  = $clog2(MAX_RETRY + 2);
   localparam logic [SW-1:0] SPAN = SW'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_LEN, S_SEND, S_ACK, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n, base, base_n;
   logic [TW-1:0]     total, total_n, idx, idx_n;
   logic [7:0]        tx_data, tx_data_n;
   logic              tx_valid, tx_valid_n;
   logic              busy, busy_n, done, done_n, err, err_n;
   logic [4:0]        frame_cnt, frame_cnt_n;
   logic [TMW-1:0]    tmr, tmr_n;
   logic [RW-1:0]     retry, retry_n, retry_inc;
   logic [GW-1:0]     gap, gap_n;
   logic [TW-1:0]     len_total;
   logic [SW-1:0]     next_base;
   logic              goto_gap;

   assign len_total = TW'(iRomData) + TW'(4);
   assign next_base = SW'(base) + SW'(total);
   assign retry_inc = retry + RW'(1);

   always_ff @(posedge iClk or negedge iRst_N) begin
      if (!iRst_N) begin
         state     <= S_IDLE;
         addr      <= '0;
         base      <= '0;
         total     <= '0;
         idx       <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         frame_cnt <= '0;
         tmr       <= '0;
         retry     <= '0;
         gap       <= '0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         base      <= base_n;
         total     <= total_n;
         idx       <= idx_n;
         tx_data   <= tx_data_n;
         tx_valid  <= tx_valid_n;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
         frame_cnt <= frame_cnt_n;
         tmr       <= tmr_n;
         retry     <= retry_n;
         gap       <= gap_n;
      end
   end

   always_comb begin
      state_n     = state;
      addr_n      = addr;
      base_n      = base;
      total_n     = total;
      idx_n       = idx;
      tx_data_n   = tx_data;
      tx_valid_n  = tx_valid;
      busy_n      = busy;
      done_n      = 1'b0;
      err_n       = err;
      frame_cnt_n = frame_cnt;
      tmr_n       = tmr;
      retry_n     = retry;
      gap_n       = gap;
      goto_gap    = 1'b0;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (iStart) begin
               state_n     = S_HDR;
               addr_n      = '0;
               base_n      = '0;
               frame_cnt_n = '0;
               retry_n     = '0;
               err_n       = 1'b0;
               busy_n      = 1'b1;
            end
         end
         S_HDR: begin
            if (iRomData != 8'hAA) begin
               state_n = S_DONE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               base_n  = addr;
               addr_n  = addr + ADDR_W'(1);
               state_n = S_LEN;
            end
         end
         S_LEN: begin
            total_n = len_total;
            if ((iRomData < 8'd2) || ((SW'(base) + SW'(len_total)) > SPAN)) begin
               state_n = S_ERR;
               err_n   = 1'b1;
               busy_n  = 1'b0;
            end else begin
               addr_n  = base;
               idx_n   = '0;
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            // addr runs one byte ahead of tx_data so the next byte loads on the accept edge
            if (!tx_valid) begin
               tx_data_n  = iRomData;
               tx_valid_n = 1'b1;
               addr_n     = addr + ADDR_W'(1);
            end else if (iTxReady) begin
               if (idx == total - TW'(1)) begin
                  tx_valid_n = 1'b0;
                  if (ACK_EN != 0) begin
                     state_n = S_ACK;
                     tmr_n   = '0;
                  end else begin
                     goto_gap = 1'b1;
                  end
               end else begin
                  idx_n     = idx + TW'(1);
                  tx_data_n = iRomData;
                  addr_n    = addr + ADDR_W'(1);
               end
            end
         end
         S_ACK: begin
            if (iRxValid && (iRxData == ACK_BYTE)) begin
               goto_gap = 1'b1;
            end else if (tmr == TMW'(ACK_TMO - 1)) begin
               retry_n = retry_inc;
               if (retry_inc <= RW'(MAX_RETRY)) begin
                  addr_n  = base;
                  idx_n   = '0;
                  state_n = S_SEND;
               end else begin
                  state_n = S_ERR;
                  err_n   = 1'b1;
                  busy_n  = 1'b0;
               end
            end else begin
               tmr_n = tmr + TMW'(1);
            end
         end
         S_GAP: begin
            if (gap == GW'(GAP_CYCLES - 1)) begin
               if ((frame_cnt >= 5'(MAX_FRAMES)) || (next_base >= SPAN)) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  state_n = S_HDR;
               end
            end else begin
               gap_n = gap + GW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (goto_gap) begin
         state_n     = S_GAP;
         frame_cnt_n = frame_cnt + 5'd1;
         retry_n     = '0;
         addr_n      = ADDR_W'(next_base);
         gap_n       = '0;
      end
   end

   assign oRomAddr  = addr;
   assign oTxData   = tx_data;
   assign oTxValid  = tx_valid;
   assign oBusy     = busy;
   assign oDone     = done;
   assign oErr      = err;
   assign oFrameCnt = frame_cnt;

endmodule

// File: tb/tb_ir_cfg_sequencer.sv
// Scoreboard bench for ir_cfg_sequencer: two instances (ACK off / ACK on) share a table model;
// expected TX bytes are queued at stimulus time and popped on each observed handshake.
module tb_ir_cfg_sequencer;

   localparam int unsigned GAP   = 5;
   localparam int unsigned TMO   = 40;
   localparam int unsigned RETRY = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start1, tx_ready, rx_valid;
   logic [7:0] rx_data;
   logic [7:0] rom [256];
   logic [7:0] addr0, addr1, txd0, txd1, romd0, romd1;
   logic       txv0, txv1, busy0, busy1, done0, done1, err0, err1;
   logic [4:0] fc0, fc1;
   logic       sel;

   always #5 clk = ~clk;

   assign romd0 = rom[addr0];
   assign romd1 = rom[addr1];

   ir_cfg_sequencer #(.ADDR_W(8), .MAX_FRAMES(16), .GAP_CYCLES(GAP), .ACK_EN(0),
                      .ACK_BYTE(8'h55), .ACK_TMO(TMO), .MAX_RETRY(RETRY)) dut0 (
      .iClk(clk), .iRst_N(rst_n), .iStart(start0), .oRomAddr(addr0), .iRomData(romd0),
      .oTxData(txd0), .oTxValid(txv0), .iTxReady(tx_ready), .iRxData(rx_data),
      .iRxValid(rx_valid), .oBusy(busy0), .oDone(done0), .oErr(err0), .oFrameCnt(fc0));

   ir_cfg_sequencer #(.ADDR_W(8), .MAX_FRAMES(16), .GAP_CYCLES(GAP), .ACK_EN(1),
                      .ACK_BYTE(8'h55), .ACK_TMO(TMO), .MAX_RETRY(RETRY)) dut1 (
      .iClk(clk), .iRst_N(rst_n), .iStart(start1), .oRomAddr(addr1), .iRomData(romd1),
      .oTxData(txd1), .oTxValid(txv1), .iTxReady(tx_ready), .iRxData(rx_data),
      .iRxValid(rx_valid), .oBusy(busy1), .oDone(done1), .oErr(err1), .oFrameCnt(fc1));

   logic       mv, cur_done, cur_err, cur_busy;
   logic [7:0] md;
   logic [4:0] cur_fc;
   assign mv       = sel ? txv1  : txv0;
   assign md       = sel ? txd1  : txd0;
   assign cur_done = sel ? done1 : done0;
   assign cur_err  = sel ? err1  : err0;
   assign cur_busy = sel ? busy1 : busy0;
   assign cur_fc   = sel ? fc1   : fc0;

   logic [7:0] std_tbl [19] = '{8'hAA, 8'h06, 8'h01, 8'h5D, 8'h02, 8'h05, 8'h40, 8'h55, 8'hEB, 8'hAA,
                                8'hAA, 8'h04, 8'h01, 8'h7F, 8'h02, 8'h30, 8'hEB, 8'hAA, 8'h00};

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         hs_count = 0;
   int         hs_cyc [$];
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic monitor();
      logic       prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               n_checks++;
               if (mv !== 1'b1 || md !== prev_data) begin
                  n_errors++;
                  $display("FAIL tx_hold: valid=%0b data=%h, required valid=1 data=%h", mv, md, prev_data);
               end
            end
            if (mv && tx_ready) begin
               hs_count++;
               hs_cyc.push_back(cyc);
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL tx_byte: unexpected byte %h, required none", md);
               end else begin
                  e = exp_q.pop_front();
                  if (md !== e) begin
                     n_errors++;
                     $display("FAIL tx_byte #%0d: got %h, required %h", hs_count - 1, md, e);
                  end
               end
            end
            prev_stall = mv && !tx_ready;
            prev_data  = md;
         end
      end
   endtask

   task automatic load_std_table();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      for (int i = 0; i < 19; i++) rom[i] = std_tbl[i];
   endtask

   task automatic push_bytes(input int first, input int count);
      for (int i = first; i < first + count; i++) exp_q.push_back(rom[i]);
   endtask

   task automatic clear_sb();
      exp_q.delete();
      hs_cyc.delete();
      hs_count = 0;
   endtask

   task automatic pulse_start(input logic which);
      tick();
      if (which) start1 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic run_until_end(input int budget, input bit rand_ready, output int dcnt, output bit tmo);
      dcnt = 0;
      tmo  = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
         if (cur_done) dcnt++;
         if (cur_done || cur_err) begin
            tmo = 1'b0;
            break;
         end
      end
      repeat (3) begin
         tick();
         if (cur_done) dcnt++;
      end
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({addr0, txd0, txv0, busy0, done0, err0, fc0} !== '0) begin
         n_errors++;
         $display("FAIL reset_dut0: outputs %h, required 0", {addr0, txd0, txv0, busy0, done0, err0, fc0});
      end
      n_checks++;
      if ({addr1, txd1, txv1, busy1, done1, err1, fc1} !== '0) begin
         n_errors++;
         $display("FAIL reset_dut1: outputs %h, required 0", {addr1, txd1, txv1, busy1, done1, err1, fc1});
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int dcnt;
      bit tmo, ok;
      sel = 1'b0;
      tx_ready = 1'b1;
      load_std_table();
      clear_sb();
      push_bytes(0, 18);
      pulse_start(1'b0);
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_busy: got %0b, required 1", busy0);
      end
      run_until_end(2000, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0) begin n_errors++; $display("FAIL basic_end: timed out, required done"); end
      n_checks++;
      if (dcnt !== 1) begin n_errors++; $display("FAIL basic_done_pulse: %0d cycles, required 1", dcnt); end
      n_checks++;
      if (fc0 !== 5'd2 || err0 !== 1'b0 || busy0 !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_status: fc=%0d err=%0b busy=%0b, required fc=2 err=0 busy=0", fc0, err0, busy0);
      end
      n_checks++;
      if (exp_q.size() !== 0 || hs_count !== 18) begin
         n_errors++;
         $display("FAIL basic_count: sent %0d left %0d, required sent 18 left 0", hs_count, exp_q.size());
      end
      if (hs_cyc.size() >= 18) begin
         ok = 1'b1;
         for (int i = 0; i < 17; i++)
            if (i != 9 && hs_cyc[i+1] - hs_cyc[i] != 1) ok = 1'b0;
         n_checks++;
         if (!ok) begin n_errors++; $display("FAIL basic_back_to_back: bytes not on consecutive cycles, required 1 per clk"); end
         n_checks++;
         if (hs_cyc[10] - hs_cyc[9] <= GAP) begin
            n_errors++;
            $display("FAIL basic_gap: %0d clks between frames, required > %0d", hs_cyc[10] - hs_cyc[9], GAP);
         end
      end
   endtask

   task automatic test_stall();
      int dcnt;
      bit tmo;
      sel = 1'b0;
      load_std_table();
      clear_sb();
      push_bytes(0, 18);
      pulse_start(1'b0);
      run_until_end(4000, 1'b1, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || dcnt !== 1) begin
         n_errors++;
         $display("FAIL stall_end: timeout=%0b done_pulses=%0d, required 0 and 1", tmo, dcnt);
      end
      n_checks++;
      if (fc0 !== 5'd2 || exp_q.size() !== 0 || hs_count !== 18) begin
         n_errors++;
         $display("FAIL stall_stream: fc=%0d sent=%0d left=%0d, required 2 18 0", fc0, hs_count, exp_q.size());
      end
   endtask

   task automatic test_ack();
      int dcnt = 0;
      int last;
      bit ended = 1'b0;
      sel = 1'b1;
      tx_ready = 1'b1;
      load_std_table();
      clear_sb();
      push_bytes(0, 18);
      pulse_start(1'b1);
      for (int i = 0; i < 3000 && !ended; i++) begin
         tick();
         rx_valid = 1'b0;
         if (cur_done) dcnt++;
         if (cur_done || cur_err) ended = 1'b1;
         if ((hs_count == 10 || hs_count == 18) && hs_cyc.size() > 0) begin
            last = hs_cyc[hs_cyc.size()-1];
            if (cyc == last + 5) begin
               rx_data  = 8'h12;
               rx_valid = 1'b1;
            end
            // second frame is acknowledged in the very cycle its timer expires
            if ((hs_count == 10 && cyc == last + 10) || (hs_count == 18 && cyc == last + int'(TMO))) begin
               rx_data  = 8'h55;
               rx_valid = 1'b1;
            end
         end
      end
      tick();
      rx_valid = 1'b0;
      n_checks++;
      if (!ended || dcnt !== 1) begin
         n_errors++;
         $display("FAIL ack_end: ended=%0b done_pulses=%0d, required 1 and 1", ended, dcnt);
      end
      n_checks++;
      if (err1 !== 1'b0 || fc1 !== 5'd2) begin
         n_errors++;
         $display("FAIL ack_status: err=%0b fc=%0d, required err=0 fc=2", err1, fc1);
      end
      n_checks++;
      if (hs_count !== 18 || exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL ack_count: sent %0d left %0d, required 18 and 0", hs_count, exp_q.size());
      end
   endtask

   task automatic test_retry();
      int dcnt;
      bit tmo;
      sel = 1'b1;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      load_std_table();
      clear_sb();
      repeat (RETRY + 1) push_bytes(0, 10);
      pulse_start(1'b1);
      run_until_end(3000, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || err1 !== 1'b1 || dcnt !== 0) begin
         n_errors++;
         $display("FAIL retry_err: timeout=%0b err=%0b done=%0d, required 0 1 0", tmo, err1, dcnt);
      end
      n_checks++;
      if (fc1 !== 5'd0 || busy1 !== 1'b0 || txv1 !== 1'b0) begin
         n_errors++;
         $display("FAIL retry_status: fc=%0d busy=%0b valid=%0b, required 0 0 0", fc1, busy1, txv1);
      end
      n_checks++;
      if (hs_count !== 10 * (RETRY + 1) || exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL retry_count: sent %0d left %0d, required %0d and 0", hs_count, exp_q.size(), 10 * (RETRY + 1));
      end
      if (hs_cyc.size() > 10) begin
         n_checks++;
         if (hs_cyc[10] - hs_cyc[9] != int'(TMO) + 2) begin
            n_errors++;
            $display("FAIL retry_timeout: resend after %0d clks, required %0d", hs_cyc[10] - hs_cyc[9], TMO + 2);
         end
      end
      repeat (3) tick();
      n_checks++;
      if (err1 !== 1'b1) begin n_errors++; $display("FAIL retry_err_held: got %0b, required 1", err1); end
      pulse_start(1'b1);
      n_checks++;
      if (err1 !== 1'b0 || busy1 !== 1'b1) begin
         n_errors++;
         $display("FAIL retry_restart: err=%0b busy=%0b, required 0 1", err1, busy1);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bad_frame();
      int dcnt;
      bit tmo;
      sel = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[0] = 8'hAA;
      rom[1] = 8'h01;
      rom[2] = 8'h33;
      clear_sb();
      pulse_start(1'b0);
      run_until_end(100, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || err0 !== 1'b1 || busy0 !== 1'b0 || hs_count !== 0 || fc0 !== 5'd0) begin
         n_errors++;
         $display("FAIL short_len: err=%0b busy=%0b sent=%0d fc=%0d, required 1 0 0 0", err0, busy0, hs_count, fc0);
      end
      rom[0] = 8'h00;
      pulse_start(1'b0);
      run_until_end(100, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || dcnt !== 1 || err0 !== 1'b0 || fc0 !== 5'd0 || hs_count !== 0) begin
         n_errors++;
         $display("FAIL empty_table: done=%0d err=%0b fc=%0d sent=%0d, required 1 0 0 0", dcnt, err0, fc0, hs_count);
      end
   endtask

   task automatic test_boundary();
      int dcnt;
      bit tmo;
      sel = 1'b0;
      rom[0] = 8'hAA;
      rom[1] = 8'hFC;
      for (int i = 2; i < 256; i++) rom[i] = 8'(i) ^ 8'h3C;
      clear_sb();
      push_bytes(0, 256);
      pulse_start(1'b0);
      run_until_end(1500, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || dcnt !== 1 || err0 !== 1'b0 || fc0 !== 5'd1) begin
         n_errors++;
         $display("FAIL full_span: done=%0d err=%0b fc=%0d, required 1 0 1", dcnt, err0, fc0);
      end
      n_checks++;
      if (hs_count !== 256 || exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL full_span_count: sent %0d left %0d, required 256 0", hs_count, exp_q.size());
      end
      rom[1] = 8'hFD;
      clear_sb();
      pulse_start(1'b0);
      run_until_end(100, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || err0 !== 1'b1 || hs_count !== 0) begin
         n_errors++;
         $display("FAIL overflow_len: err=%0b sent=%0d, required 1 0", err0, hs_count);
      end
   endtask

   task automatic test_reset_mid();
      int dcnt;
      bit tmo;
      bit hit = 1'b0;
      sel = 1'b0;
      tx_ready = 1'b1;
      load_std_table();
      clear_sb();
      push_bytes(0, 18);
      pulse_start(1'b0);
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (hs_count == 5) hit = 1'b1;
      end
      n_checks++;
      if (!hit || txv0 !== 1'b1 || txd0 !== 8'h05) begin
         n_errors++;
         $display("FAIL mid_byte5: reached=%0b valid=%0b data=%h, required 1 1 05", hit, txv0, txd0);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({addr0, txd0, txv0, busy0, done0, err0, fc0} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset: outputs %h, required 0", {addr0, txd0, txv0, busy0, done0, err0, fc0});
      end
      tick();
      clear_sb();
      rst_n = 1'b1;
      tick();
      push_bytes(0, 18);
      pulse_start(1'b0);
      run_until_end(2000, 1'b0, dcnt, tmo);
      n_checks++;
      if (tmo !== 1'b0 || dcnt !== 1 || fc0 !== 5'd2 || hs_count !== 18 || exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL mid_restart: done=%0d fc=%0d sent=%0d left=%0d, required 1 2 18 0",
                  dcnt, fc0, hs_count, exp_q.size());
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start0   = 1'b0;
      start1   = 1'b0;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      sel      = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      fork
         monitor();
         begin
            test_reset();
            test_basic();
            test_stall();
            test_ack();
            test_retry();
            test_bad_frame();
            test_boundary();
            test_reset_mid();
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
